// File: rtl/tcam_lookup_arb.sv
// tcam_lookup_arb
//   Shares the single TCAM lookup port among PORT_NUM requesters using a
//   round-robin grant. Each issued lookup pushes its requester index into an
//   in-order tag FIFO, and each TCAM result pops that FIFO to steer the
//   result back to the requester that issued it. The number of lookups in
//   flight is capped at MAX_OUTSTANDING. Issue can optionally be held off
//   while the TCAM is being reconfigured.
//
// Ports
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_req_data/i_req_vld  per-requester key (k at [k*W +: W]) and valid
//   o_req_rdy             one-hot grant, combinational
//   o_look_up_data[_vld]  registered key and strobe to the TCAM
//   i_acl_*               TCAM result (frmtype, fetchinfo, vld)
//   i_tcam_busy           TCAM configuration in progress
//   o_rsp_*               registered result, o_rsp_vld one-hot to its owner
//   o_outstanding         lookups currently in flight
//   o_err_unexp_rsp       one-cycle pulse: result arrived with nothing in flight
module tcam_lookup_arb #(
  parameter int PORT_NUM           = 4,
  parameter int LOOK_UP_DATA_WIDTH = 280,
  parameter int MAX_OUTSTANDING    = 4,
  parameter int BLOCK_ON_BUSY      = 1
) (
  input  logic                                   i_clk,
  input  logic                                   i_rst,
  input  logic [PORT_NUM*LOOK_UP_DATA_WIDTH-1:0] i_req_data,
  input  logic [PORT_NUM-1:0]                    i_req_vld,
  output logic [PORT_NUM-1:0]                    o_req_rdy,
  output logic [LOOK_UP_DATA_WIDTH-1:0]          o_look_up_data,
  output logic                                   o_look_up_data_vld,
  input  logic [7:0]                             i_acl_frmtype,
  input  logic [15:0]                            i_acl_fetchinfo,
  input  logic                                   i_acl_vld,
  input  logic                                   i_tcam_busy,
  output logic [7:0]                             o_rsp_frmtype,
  output logic [15:0]                            o_rsp_fetchinfo,
  output logic [PORT_NUM-1:0]                    o_rsp_vld,
  output logic [$clog2(MAX_OUTSTANDING):0]       o_outstanding,
  output logic                                   o_err_unexp_rsp
);

  localparam int W     = LOOK_UP_DATA_WIDTH;
  localparam int PTR_W = $clog2(PORT_NUM);
  localparam int AW    = $clog2(MAX_OUTSTANDING);
  localparam int CW    = AW + 1;

  // Unpacked view of the requester keys for a clean indexed mux.
  logic [W-1:0] req_key [PORT_NUM];

  genvar gi;
  generate
    for (gi = 0; gi < PORT_NUM; gi++) begin : g_unpack
      assign req_key[gi] = i_req_data[gi*W +: W];
    end
  endgenerate

  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [PTR_W-1:0]    tag_mem_q [MAX_OUTSTANDING];
  logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [W-1:0]        look_up_data_q;
  logic                look_up_vld_q;
  logic [7:0]          rsp_frmtype_q;
  logic [15:0]         rsp_fetchinfo_q;
  logic [PORT_NUM-1:0] rsp_vld_q, rsp_vld_d;
  logic                err_q;

  logic                can_issue;
  logic                found;
  logic                pop;
  logic [PORT_NUM-1:0] gnt;
  logic [PTR_W-1:0]    gnt_idx;
  logic [PTR_W:0]      scan_idx;

  // Credit check uses the registered count, so a pop frees a slot for the
  // following cycle. No grant while reset is held, otherwise a requester
  // would see its request accepted and then lost.
  assign can_issue = !i_rst
                   && (cnt_q < CW'(MAX_OUTSTANDING))
                   && !((BLOCK_ON_BUSY != 0) && i_tcam_busy);

  // Round-robin scan starting at ptr_q; the index wraps without a modulo so
  // non power-of-two PORT_NUM works.
  always_comb begin
    gnt      = '0;
    gnt_idx  = '0;
    found    = 1'b0;
    scan_idx = '0;
    for (int i = 0; i < PORT_NUM; i++) begin
      scan_idx = {1'b0, ptr_q} + (PTR_W+1)'(i);
      if (scan_idx >= (PTR_W+1)'(PORT_NUM)) begin
        scan_idx = scan_idx - (PTR_W+1)'(PORT_NUM);
      end
      if (can_issue && !found && i_req_vld[scan_idx[PTR_W-1:0]]) begin
        found                        = 1'b1;
        gnt_idx                      = scan_idx[PTR_W-1:0];
        gnt[scan_idx[PTR_W-1:0]]     = 1'b1;
      end
    end
  end

  assign pop   = i_acl_vld && (cnt_q != '0);
  assign ptr_d = (gnt_idx == PTR_W'(PORT_NUM - 1)) ? '0 : gnt_idx + 1'b1;

  always_comb begin
    cnt_d = cnt_q;
    case ({found, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  assign rsp_vld_d = PORT_NUM'(1) << tag_mem_q[rd_ptr_q];

  // Tag storage needs no reset: entries are only read between push and pop.
  always_ff @(posedge i_clk) begin
    if (found) begin
      tag_mem_q[wr_ptr_q] <= gnt_idx;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ptr_q           <= '0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      cnt_q           <= '0;
      look_up_data_q  <= '0;
      look_up_vld_q   <= 1'b0;
      rsp_frmtype_q   <= '0;
      rsp_fetchinfo_q <= '0;
      rsp_vld_q       <= '0;
      err_q           <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      look_up_vld_q <= found;
      rsp_vld_q     <= '0;
      err_q         <= i_acl_vld && (cnt_q == '0);
      if (found) begin
        look_up_data_q <= req_key[gnt_idx];
        wr_ptr_q       <= wr_ptr_q + 1'b1;
        ptr_q          <= ptr_d;
      end
      if (pop) begin
        rd_ptr_q        <= rd_ptr_q + 1'b1;
        rsp_vld_q       <= rsp_vld_d;
        rsp_frmtype_q   <= i_acl_frmtype;
        rsp_fetchinfo_q <= i_acl_fetchinfo;
      end
    end
  end

  assign o_req_rdy          = gnt;
  assign o_look_up_data     = look_up_data_q;
  assign o_look_up_data_vld = look_up_vld_q;
  assign o_rsp_frmtype      = rsp_frmtype_q;
  assign o_rsp_fetchinfo    = rsp_fetchinfo_q;
  assign o_rsp_vld          = rsp_vld_q;
  assign o_outstanding      = cnt_q;
  assign o_err_unexp_rsp    = err_q;

endmodule

// File: tb/tb_tcam_lookup_arb.sv
// Testbench for tcam_lookup_arb: directed scenarios followed by randomized
// traffic, all checked against a transaction-level model (a queue of issued
// requester indices plus a round-robin pointer). A second instance with
// BLOCK_ON_BUSY=0 shares the stimulus and is checked during the busy test.
module tb_tcam_lookup_arb;
  localparam int P    = 4;
  localparam int W    = 280;
  localparam int MAXO = 4;

  logic           i_clk = 1'b0;
  logic           i_rst = 1'b1;
  logic [P*W-1:0] i_req_data = '0;
  logic [P-1:0]   i_req_vld = '0;
  logic [7:0]     i_acl_frmtype = '0;
  logic [15:0]    i_acl_fetchinfo = '0;
  logic           i_acl_vld = 1'b0;
  logic           i_tcam_busy = 1'b0;

  logic [P-1:0]   o_req_rdy, nb_req_rdy;
  logic [W-1:0]   o_look_up_data, nb_look_up_data;
  logic           o_look_up_data_vld, nb_look_up_data_vld;
  logic [7:0]     o_rsp_frmtype, nb_rsp_frmtype;
  logic [15:0]    o_rsp_fetchinfo, nb_rsp_fetchinfo;
  logic [P-1:0]   o_rsp_vld, nb_rsp_vld;
  logic [2:0]     o_outstanding, nb_outstanding;
  logic           o_err_unexp_rsp, nb_err_unexp_rsp;

  tcam_lookup_arb #(.PORT_NUM(P), .LOOK_UP_DATA_WIDTH(W),
                    .MAX_OUTSTANDING(MAXO), .BLOCK_ON_BUSY(1)) u_dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_req_data(i_req_data), .i_req_vld(i_req_vld),
    .o_req_rdy(o_req_rdy), .o_look_up_data(o_look_up_data),
    .o_look_up_data_vld(o_look_up_data_vld), .i_acl_frmtype(i_acl_frmtype),
    .i_acl_fetchinfo(i_acl_fetchinfo), .i_acl_vld(i_acl_vld), .i_tcam_busy(i_tcam_busy),
    .o_rsp_frmtype(o_rsp_frmtype), .o_rsp_fetchinfo(o_rsp_fetchinfo),
    .o_rsp_vld(o_rsp_vld), .o_outstanding(o_outstanding), .o_err_unexp_rsp(o_err_unexp_rsp)
  );

  tcam_lookup_arb #(.PORT_NUM(P), .LOOK_UP_DATA_WIDTH(W),
                    .MAX_OUTSTANDING(MAXO), .BLOCK_ON_BUSY(0)) u_dut_nb (
    .i_clk(i_clk), .i_rst(i_rst), .i_req_data(i_req_data), .i_req_vld(i_req_vld),
    .o_req_rdy(nb_req_rdy), .o_look_up_data(nb_look_up_data),
    .o_look_up_data_vld(nb_look_up_data_vld), .i_acl_frmtype(i_acl_frmtype),
    .i_acl_fetchinfo(i_acl_fetchinfo), .i_acl_vld(i_acl_vld), .i_tcam_busy(i_tcam_busy),
    .o_rsp_frmtype(nb_rsp_frmtype), .o_rsp_fetchinfo(nb_rsp_fetchinfo),
    .o_rsp_vld(nb_rsp_vld), .o_outstanding(nb_outstanding), .o_err_unexp_rsp(nb_err_unexp_rsp)
  );

  always #5 i_clk = ~i_clk;

  int checks;
  int errors;

  // Requester model: each port holds its key until accepted.
  bit           req_vld_m [P];
  logic [W-1:0] req_key_m [P];
  bit           rearm;

  // Reference model state.
  int           m_ptr;
  int           m_q[$];
  int           gorder[$];
  int           last_g;
  logic         exp_lvld;
  logic [W-1:0] exp_ldata;
  logic [P-1:0] exp_rsp_vld;
  logic [7:0]   exp_frm;
  logic [15:0]  exp_fetch;
  logic         exp_err;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] rnd_key();
    logic [W-1:0] k;
    k = '0;
    for (int i = 0; i < 9; i++) k = {k[W-33:0], 32'($urandom)};
    return k;
  endfunction

  task automatic drive();
    for (int k = 0; k < P; k++) begin
      i_req_vld[k]          = req_vld_m[k];
      i_req_data[k*W +: W]  = req_key_m[k];
    end
  endtask

  // One clock cycle: check the combinational grant, advance the model, clock,
  // then check every registered output.
  task automatic cycle();
    int           g;
    int           t;
    bit           rst_now;
    logic [P-1:0] exp_rdy;
    drive();
    #1;
    rst_now = i_rst;
    g = -1;
    if (!i_rst && m_q.size() < MAXO && !i_tcam_busy) begin
      for (int i = 0; i < P; i++) begin
        if (g < 0 && req_vld_m[(m_ptr + i) % P]) g = (m_ptr + i) % P;
      end
    end
    exp_rdy = (g >= 0) ? (P'(1) << g) : '0;
    chk("req_rdy", o_req_rdy, exp_rdy);
    last_g = g;
    if (i_rst) begin
      m_q.delete();
      m_ptr = 0;
      exp_lvld = 0; exp_ldata = '0; exp_rsp_vld = '0;
      exp_frm = '0; exp_fetch = '0; exp_err = 0;
    end else begin
      exp_lvld    = (g >= 0);
      exp_err     = 0;
      exp_rsp_vld = '0;
      if (i_acl_vld) begin
        if (m_q.size() > 0) begin
          t = m_q.pop_front();
          exp_rsp_vld = P'(1) << t;
          exp_frm     = i_acl_frmtype;
          exp_fetch   = i_acl_fetchinfo;
          $display("rsp  port %0d frmtype %02h fetchinfo %04h", t, exp_frm, exp_fetch);
        end else begin
          exp_err = 1;
          $display("rsp  unexpected (nothing in flight)");
        end
      end
      if (g >= 0) begin
        m_q.push_back(g);
        exp_ldata = req_key_m[g];
        m_ptr = (g + 1) % P;
        gorder.push_back(g);
        $display("issue port %0d outstanding %0d", g, m_q.size());
      end
    end
    @(posedge i_clk);
    #1;
    chk("look_up_vld", o_look_up_data_vld, exp_lvld);
    if (exp_lvld || rst_now) chk("look_up_data", o_look_up_data, exp_ldata);
    chk("rsp_vld", o_rsp_vld, exp_rsp_vld);
    chk("rsp_frmtype", o_rsp_frmtype, exp_frm);
    chk("rsp_fetchinfo", o_rsp_fetchinfo, exp_fetch);
    chk("outstanding", o_outstanding, m_q.size());
    chk("err_unexp", o_err_unexp_rsp, exp_err);
    i_acl_vld = 1'b0;
    if (g >= 0) begin
      if (rearm) req_key_m[g] = rnd_key();
      else       req_vld_m[g] = 0;
    end
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    cycle();
    cycle();
    i_rst = 1'b0;
  endtask

  task automatic clear_reqs();
    rearm = 0;
    for (int k = 0; k < P; k++) req_vld_m[k] = 0;
  endtask

  task automatic drain();
    for (int n = 0; n < 2 * MAXO && m_q.size() > 0; n++) begin
      i_acl_vld       = 1'b1;
      i_acl_frmtype   = 8'($urandom);
      i_acl_fetchinfo = 16'($urandom);
      cycle();
    end
  endtask

  initial begin
    checks = 0; errors = 0; m_ptr = 0; rearm = 0; last_g = -1;
    exp_lvld = 0; exp_ldata = '0; exp_rsp_vld = '0; exp_frm = '0; exp_fetch = '0; exp_err = 0;
    for (int k = 0; k < P; k++) begin req_vld_m[k] = 0; req_key_m[k] = '0; end

    // Reset state.
    do_reset();
    chk("reset_outstanding", o_outstanding, 0);

    // Single requester on port 2.
    req_key_m[2] = {35{8'hAB}};
    req_vld_m[2] = 1;
    cycle();
    chk("single_key", o_look_up_data, {35{8'hAB}});
    chk("single_lvld", o_look_up_data_vld, 1);
    cycle();
    i_acl_vld = 1'b1; i_acl_frmtype = 8'h11; i_acl_fetchinfo = 16'h1234;
    cycle();
    chk("single_rsp_vld", o_rsp_vld, 4'b0100);
    chk("single_frm", o_rsp_frmtype, 8'h11);
    chk("single_fetch", o_rsp_fetchinfo, 16'h1234);
    chk("single_outst", o_outstanding, 0);

    // Fairness: all ports continuously valid, one response per cycle.
    do_reset();
    rearm = 1;
    for (int k = 0; k < P; k++) begin req_vld_m[k] = 1; req_key_m[k] = rnd_key(); end
    gorder.delete();
    cycle();
    for (int n = 0; n < 7; n++) begin
      i_acl_vld = 1'b1; i_acl_frmtype = 8'($urandom); i_acl_fetchinfo = 16'($urandom);
      cycle();
    end
    for (int n = 0; n < 8; n++) chk("fair_order", gorder[n], n % P);
    clear_reqs();
    drain();

    // Credit limit.
    do_reset();
    rearm = 1;
    for (int k = 0; k < P; k++) begin req_vld_m[k] = 1; req_key_m[k] = rnd_key(); end
    for (int n = 0; n < 5; n++) cycle();
    chk("credit_full", o_outstanding, 4);
    drive(); #1;
    chk("credit_rdy0", o_req_rdy, 4'b0000);
    i_acl_vld = 1'b1;
    cycle();
    chk("credit_pop", o_outstanding, 3);
    i_acl_vld = 1'b1;
    cycle();
    chk("credit_regrant", o_look_up_data_vld, 1);
    chk("credit_pushpop", o_outstanding, 3);
    clear_reqs();
    drain();

    // Busy hold, with the non-blocking instance issuing anyway.
    do_reset();
    req_vld_m[0] = 1; req_key_m[0] = rnd_key();
    req_vld_m[1] = 1; req_key_m[1] = rnd_key();
    i_tcam_busy = 1'b1;
    drive(); #1;
    chk("nb_busy_rdy", nb_req_rdy, 4'b0001);
    cycle();
    chk("nb_busy_issue", nb_look_up_data_vld, 1);
    cycle();
    chk("busy_no_issue", o_look_up_data_vld, 0);
    i_tcam_busy = 1'b0;
    cycle();
    chk("busy_release", o_look_up_data_vld, 1);
    cycle();
    drain();

    // Unexpected response.
    do_reset();
    i_acl_vld = 1'b1;
    cycle();
    chk("unexp_err", o_err_unexp_rsp, 1);
    chk("unexp_rsp", o_rsp_vld, 4'b0000);
    chk("unexp_outst", o_outstanding, 0);
    cycle();
    chk("unexp_pulse", o_err_unexp_rsp, 0);

    // Reset with two lookups in flight.
    do_reset();
    req_vld_m[0] = 1; req_key_m[0] = rnd_key();
    req_vld_m[1] = 1; req_key_m[1] = rnd_key();
    cycle();
    cycle();
    chk("mid_outst", o_outstanding, 2);
    i_rst = 1'b1;
    cycle();
    i_rst = 1'b0;
    chk("mid_rst_outst", o_outstanding, 0);
    chk("mid_rst_lvld", o_look_up_data_vld, 0);
    for (int n = 0; n < 2; n++) begin
      i_acl_vld = 1'b1;
      cycle();
      chk("mid_err", o_err_unexp_rsp, 1);
      chk("mid_rsp", o_rsp_vld, 4'b0000);
    end

    // Randomized traffic.
    do_reset();
    for (int n = 0; n < 600; n++) begin
      for (int k = 0; k < P; k++) begin
        if (!req_vld_m[k] && $urandom_range(0, 2) == 0) begin
          req_vld_m[k] = 1;
          req_key_m[k] = rnd_key();
        end
      end
      i_tcam_busy = ($urandom_range(0, 9) < 2);
      if (m_q.size() > 0) i_acl_vld = ($urandom_range(0, 1) == 1);
      else                i_acl_vld = ($urandom_range(0, 19) == 0);
      i_acl_frmtype   = 8'($urandom);
      i_acl_fetchinfo = 16'($urandom);
      i_rst = ($urandom_range(0, 99) == 0);
      cycle();
      i_rst = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tcam_lookup_arb.md
Name: tcam_lookup_arb

Overview:
Round-robin arbiter that shares the single TCAM lookup port (i_look_up_data / i_look_up_data_vld of the TCAM top) among PORT_NUM ingress requesters. It tags each issued lookup with its requester index in an in-order tag FIFO, and steers the returned ACL action (frmtype, fetchinfo, vld) back to the requester that issued it. It caps outstanding lookups and can hold off issue while the TCAM is being reconfigured.

Parameters:
PORT_NUM, 4, number of requesters (2..8)
LOOK_UP_DATA_WIDTH, 280, lookup key width per requester
MAX_OUTSTANDING, 4, tag FIFO depth / max in-flight lookups (power of 2, >=2)
BLOCK_ON_BUSY, 1, 1 = stop issuing while i_tcam_busy=1; 0 = ignore busy

Ports:
i_clk  in  1  clock
i_rst  in  1  reset, synchronous, active-high
i_req_data  in  PORT_NUM*LOOK_UP_DATA_WIDTH  key of requester k at bits [k*W +: W]
i_req_vld  in  PORT_NUM  per-requester request valid
o_req_rdy  out  PORT_NUM  one-hot grant / accept
o_look_up_data  out  LOOK_UP_DATA_WIDTH  key to TCAM
o_look_up_data_vld  out  1  key valid to TCAM
i_acl_frmtype  in  8  TCAM result
i_acl_fetchinfo  in  16  TCAM result
i_acl_vld  in  1  TCAM result valid
i_tcam_busy  in  1  TCAM config in progress
o_rsp_frmtype  out  8  routed result
o_rsp_fetchinfo  out  16  routed result
o_rsp_vld  out  PORT_NUM  one-hot result valid to owning requester
o_outstanding  out  clog2(MAX_OUTSTANDING)+1  in-flight lookup count
o_err_unexp_rsp  out  1  one-cycle pulse: i_acl_vld with no lookup in flight

Behaviour:
- Reset: every output is 0; RR pointer = 0; tag FIFO empty; outstanding count = 0.
- can_issue = (outstanding < MAX_OUTSTANDING) && !(BLOCK_ON_BUSY && i_tcam_busy).
- Grant (combinational): if can_issue, o_req_rdy = one-hot of the first k with i_req_vld[k]=1, scanning ptr, ptr+1, ... mod PORT_NUM. Otherwise o_req_rdy = 0. o_req_rdy is never asserted without the matching i_req_vld.
- Handshake: a transfer occurs when i_req_vld[k] && o_req_rdy[k]. A requester holds its vld and data stable until accepted.
- Issue: one cycle after the transfer, o_look_up_data = the accepted key and o_look_up_data_vld = 1 for exactly one cycle. In the same edge, k is pushed into the tag FIFO and ptr becomes (k+1) mod PORT_NUM. If there is no transfer, ptr holds and vld = 0. Back-to-back issue is allowed, one per cycle.
- Response: on i_acl_vld=1 with the FIFO non-empty, pop the head tag t. The next cycle drives o_rsp_vld = 1<<t for one cycle, with frmtype and fetchinfo registered from the inputs. Responses are assumed in issue order, since the TCAM is fixed-latency and in-order.
- Response with an empty FIFO: drop it; o_rsp_vld stays 0; o_err_unexp_rsp = 1 for one cycle (registered); counters are unchanged.
- When o_rsp_vld = 0, the rsp data outputs hold their last value.
- Outstanding count: +1 on push, -1 on pop, unchanged when push and pop occur in the same cycle. It must never exceed MAX_OUTSTANDING or underflow.
- FIFO full: all rdy stay low until a pop. A pop in cycle N allows a grant in cycle N+1, because can_issue uses the registered count.
- Busy: the rising edge of i_tcam_busy blocks new grants in that same cycle. In-flight lookups still complete and route normally.
- Reset mid-operation: the FIFO, count and ptr are cleared. Any later TCAM responses for pre-reset lookups are reported via o_err_unexp_rsp.

Test Plan:
- Single requester: port 2 vld with key 0xAB..; after 1 cycle, look_up_vld=1 with that key. Inject acl_vld with frmtype=0x11, fetchinfo=0x1234 -> next cycle o_rsp_vld=4'b0100, data match, o_outstanding returns to 0.
- Fairness: all 4 ports hold vld continuously with MAX_OUTSTANDING=4 and responses returned every cycle -> grant order 0,1,2,3,0,1; each result routes to its issuing port in order.
- Credit limit: 4 issues with no responses -> o_outstanding=4 and rdy=0. One response -> o_outstanding=3; a grant happens in the next cycle; a simultaneous push and pop keeps the count at 3.
- Busy hold: i_tcam_busy=1 with ports 0 and 1 valid -> no rdy and no lookup issued. Deassert busy -> port at ptr granted the same cycle. Repeat with BLOCK_ON_BUSY=0 -> issue continues during busy.
- Unexpected response: acl_vld with an empty FIFO -> o_err_unexp_rsp pulses once; o_rsp_vld=0; o_outstanding stays 0.
- Reset mid-flight: 2 lookups outstanding, assert i_rst for 1 cycle -> all outputs 0. Then 2 acl_vld pulses -> 2 err pulses and no rsp_vld.
